// File: rtl/cpu_pkg.sv
// Shared types and constants for the core front end.
package cpu_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned ADDR_W  = 32;
    localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    // A fetch address is legal only if word aligned and inside the memory.
    function automatic logic fetch_addr_illegal(input logic [ADDR_W-1:0] pc,
                                                input logic [ADDR_W-1:0] last_addr);
        return (pc[1:0] != 2'b00) || (pc > last_addr);
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: capture on enable, drop valid on flush, otherwise hold.
module if_id_reg
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en_i,
    input  logic               flush_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [ADDR_W-1:0]  pc_i,
    input  logic [ADDR_W-1:0]  pc4_i,
    output logic               valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [ADDR_W-1:0]  pc_o,
    output logic [ADDR_W-1:0]  pc4_o
);

    logic               valid_q;
    logic [INSTR_W-1:0] instr_q;
    logic [ADDR_W-1:0]  pc_q;
    logic [ADDR_W-1:0]  pc4_q;

    // Flush only kills valid; the payload fields keep their last captured value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            instr_q <= NOP_WORD;
            pc_q    <= '0;
            pc4_q   <= '0;
        end else if (flush_i) begin
            // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
            valid_q <= 1'b0;
        end else if (en_i) begin
            valid_q <= 1'b1;
            instr_q <= instr_i;
            pc_q    <= pc_i;
            pc4_q   <= pc4_i;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;
    assign pc4_o   = pc4_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC register, boot/run/halt FSM, illegal-address trap and IF/ID capture.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC   = 32'd100,
    parameter int unsigned       IMEM_BYTES = 16384,
    parameter int unsigned       CNT_W      = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               if_id_valid,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [ADDR_W-1:0]  if_id_pc,
    output logic [ADDR_W-1:0]  if_id_pc4,
    output logic               fetch_err,
    output logic               halted,
    output logic [CNT_W-1:0]   fetch_count
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMEM_BYTES - 4);

    fetch_state_e      state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_plus4;
    logic              fetch_err_q;
    logic              halted_q;
    logic [CNT_W-1:0]  fetch_count_q;

    logic do_redirect;
    logic do_fault;
    logic do_advance;

    assign pc_plus4 = pc_q + 32'd4;

    // Decode this cycle's action in RUN with priority redirect > stall > fault/advance.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        do_redirect = 1'b0;
        do_fault    = 1'b0;
        do_advance  = 1'b0;
        if (state_q == RUN) begin
            if (redirect_valid) begin
                do_redirect = 1'b1;
            end else if (!stall) begin
                if (fetch_addr_illegal(pc_q, LAST_ADDR)) begin
                    do_fault = 1'b1;
                end else begin
                    do_advance = 1'b1;
                end
            end
        end
    end

    // FSM, PC and status registers; HALT is absorbing until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            fetch_err_q   <= 1'b0;
            halted_q      <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            case (state_q)
                BOOT: state_q <= RUN;
                RUN: begin
                    if (do_redirect) begin
                        pc_q <= redirect_pc;
                    end else if (do_fault) begin
                        state_q     <= HALT;
                        fetch_err_q <= 1'b1;
                        halted_q    <= 1'b1;
                    end else if (do_advance) begin
                        pc_q          <= pc_plus4;
                        fetch_count_q <= fetch_count_q + CNT_W'(1);
                    end
                end
                HALT:    state_q <= HALT;
                default: state_q <= HALT;
            endcase
        end
    end

    if_id_reg u_if_id_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (do_advance),
        .flush_i (do_redirect | do_fault),
        .instr_i (imem_data),
        .pc_i    (pc_q),
        .pc4_i   (pc_plus4),
        .valid_o (if_id_valid),
        .instr_o (if_id_instr),
        .pc_o    (if_id_pc),
        .pc4_o   (if_id_pc4)
    );

    assign imem_addr   = pc_q;
    assign fetch_err   = fetch_err_q;
    assign halted      = halted_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed table-driven bench for the fetch stage, with a word-level memory model.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic        fetch_err;
    logic        halted;
    logic [31:0] fetch_count;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        stall;
        logic        rv;
        logic [31:0] rpc;
        logic        ev;
        logic [31:0] ei;
        logic [31:0] ep;
        logic [31:0] ep4;
        logic [31:0] ea;
        logic        ee;
        logic        eh;
        logic [31:0] ec;
    } vec_t;

    vec_t tbl1[14];
    vec_t tbl2[6];
    vec_t tbl3[3];

    always #5 clk = ~clk;

    // Big-endian memory contents seen as words; unlisted words get an address-tagged filler.
    function automatic logic [31:0] imem_word(input logic [31:0] a);
        case (a)
            32'd100: return 32'h4808_0000;
            32'd104: return 32'h4809_0004;
            32'd232: return 32'h0C09_8842;
            default: return {16'hA5A5, a[15:0]};
        endcase
    endfunction

    assign imem_data = imem_word(imem_addr);

    instr_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_id_valid    (if_id_valid),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .if_id_pc4      (if_id_pc4),
        .fetch_err      (fetch_err),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic s, input logic rv, input logic [31:0] rpc,
                                input logic ev, input logic [31:0] ei, input logic [31:0] ep,
                                input logic [31:0] ep4, input logic [31:0] ea,
                                input logic ee, input logic eh, input logic [31:0] ec);
        vec_t v;
        v.stall = s;  v.rv = rv;  v.rpc = rpc;
        v.ev = ev;    v.ei = ei;  v.ep = ep;  v.ep4 = ep4;
        v.ea = ea;    v.ee = ee;  v.eh = eh;  v.ec = ec;
        return v;
    endfunction

    task automatic check_outputs(input string tag, input vec_t v);
        check({tag, ".valid"}, 32'(if_id_valid), 32'(v.ev));
        check({tag, ".instr"}, if_id_instr, v.ei);
        check({tag, ".pc"},    if_id_pc, v.ep);
        check({tag, ".pc4"},   if_id_pc4, v.ep4);
        check({tag, ".addr"},  imem_addr, v.ea);
        check({tag, ".err"},   32'(fetch_err), 32'(v.ee));
        check({tag, ".halted"},32'(halted), 32'(v.eh));
        check({tag, ".count"}, fetch_count, v.ec);
    endtask

    // Drive one vector, clock it, then sample 1ns after the edge.
    task automatic apply(input string tag, input vec_t v);
        stall          = v.stall;
        redirect_valid = v.rv;
        redirect_pc    = v.rpc;
        @(posedge clk);
        #1;
        check_outputs(tag, v);
    endtask

    task automatic check_reset_state(input string tag);
        check_outputs(tag, mk(0, 0, 0, 0, 0, 0, 0, 32'd100, 0, 0, 0));
    endtask

    initial begin
        // Reset release through stall, redirect-under-stall, misaligned redirect and halt.
        tbl1[0]  = mk(0, 0, 0,      0, 32'h0,         0,   0,   100,   0, 0, 0);
        tbl1[1]  = mk(0, 0, 0,      1, 32'h4808_0000, 100, 104, 104,   0, 0, 1);
        tbl1[2]  = mk(0, 0, 0,      1, 32'h4809_0004, 104, 108, 108,   0, 0, 2);
        tbl1[3]  = mk(1, 0, 0,      1, 32'h4809_0004, 104, 108, 108,   0, 0, 2);
        tbl1[4]  = mk(1, 0, 0,      1, 32'h4809_0004, 104, 108, 108,   0, 0, 2);
        tbl1[5]  = mk(1, 0, 0,      1, 32'h4809_0004, 104, 108, 108,   0, 0, 2);
        tbl1[6]  = mk(0, 0, 0,      1, 32'hA5A5_006C, 108, 112, 112,   0, 0, 3);
        tbl1[7]  = mk(1, 1, 232,    0, 32'hA5A5_006C, 108, 112, 232,   0, 0, 3);
        tbl1[8]  = mk(0, 0, 0,      1, 32'h0C09_8842, 232, 236, 236,   0, 0, 4);
        tbl1[9]  = mk(0, 1, 32'h66, 0, 32'h0C09_8842, 232, 236, 32'h66, 0, 0, 4);
        tbl1[10] = mk(0, 0, 0,      0, 32'h0C09_8842, 232, 236, 32'h66, 1, 1, 4);
        tbl1[11] = mk(1, 1, 300,    0, 32'h0C09_8842, 232, 236, 32'h66, 1, 1, 4);
        tbl1[12] = mk(1, 0, 0,      0, 32'h0C09_8842, 232, 236, 32'h66, 1, 1, 4);
        tbl1[13] = mk(0, 0, 0,      0, 32'h0C09_8842, 232, 236, 32'h66, 1, 1, 4);

        // Redirect ignored in BOOT, then run off the top of memory.
        tbl2[0] = mk(0, 1, 500,   0, 32'h0,         0,     0,     100,   0, 0, 0);
        tbl2[1] = mk(0, 1, 16376, 0, 32'h0,         0,     0,     16376, 0, 0, 0);
        tbl2[2] = mk(0, 0, 0,     1, 32'hA5A5_3FF8, 16376, 16380, 16380, 0, 0, 1);
        tbl2[3] = mk(0, 0, 0,     1, 32'hA5A5_3FFC, 16380, 16384, 16384, 0, 0, 2);
        tbl2[4] = mk(0, 0, 0,     0, 32'hA5A5_3FFC, 16380, 16384, 16384, 1, 1, 2);
        tbl2[5] = mk(1, 1, 100,   0, 32'hA5A5_3FFC, 16380, 16384, 16384, 1, 1, 2);

        // Short run used before the asynchronous reset.
        tbl3[0] = mk(0, 0, 0, 0, 32'h0,         0,   0,   100, 0, 0, 0);
        tbl3[1] = mk(0, 0, 0, 1, 32'h4808_0000, 100, 104, 104, 0, 0, 1);
        tbl3[2] = mk(0, 0, 0, 1, 32'h4809_0004, 104, 108, 108, 0, 0, 2);

        rst_n = 1'b0;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset0");
        rst_n = 1'b1;

        foreach (tbl1[i]) apply($sformatf("t1[%0d]", i), tbl1[i]);

        // Pulse reset out of HALT.
        rst_n = 1'b0;
        #1;
        check_reset_state("reset1");
        rst_n = 1'b1;
        foreach (tbl2[i]) apply($sformatf("t2[%0d]", i), tbl2[i]);

        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        foreach (tbl3[i]) apply($sformatf("t3[%0d]", i), tbl3[i]);

        // Asynchronous reset between edges in RUN must clear without a clock.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_state("async_rst");
        #2;
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
